pipe_hazard_ctrl: RTL and testbench

- Hazard, forwarding and sequencing controller for the 5-stage CPU pipeline: IF, ID, EX, MEM, WB.
- Consumes decoded opcode and register fields from the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Drives PC and pipeline-register write enables and flushes, plus ALU operand-forward selects.
- Sequences the multi-cycle MAX instruction by handshaking with the max engine, and keeps stall and flush statistics.

---
 rtl/pipe_hazard_if.sv | 50 +++++
 rtl/pipe_hazard_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_if.sv
// Signal bundle between the 5-stage pipeline datapath (master) and the
// hazard/forwarding/MAX-sequencing controller (slave).
interface pipe_hazard_if #(
  parameter int RAW   = 6,
  parameter int CNT_W = 16
);
  logic [3:0]       ifid_op;
  logic [RAW-1:0]   ifid_rs;
  logic [RAW-1:0]   ifid_rt;
  logic [3:0]       idex_op;
  logic [RAW-1:0]   idex_rs;
  logic [RAW-1:0]   idex_rt;
  logic [RAW-1:0]   idex_rd;
  logic             idex_regwrt;
  logic             idex_memread;
  logic [RAW-1:0]   exmem_rd;
  logic             exmem_regwrt;
  logic [RAW-1:0]   memwb_rd;
  logic             memwb_regwrt;
  logic             ex_redirect;
  logic             mem_redirect;
  logic             max_done;
  logic             pc_write;
  logic             ifid_write;
  logic             ifid_flush;
  logic             idex_flush;
  logic             exmem_flush;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic             max_start;
  logic             max_err;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output ifid_op, ifid_rs, ifid_rt, idex_op, idex_rs, idex_rt, idex_rd,
           idex_regwrt, idex_memread, exmem_rd, exmem_regwrt, memwb_rd,
           memwb_regwrt, ex_redirect, mem_redirect, max_done,
    input  pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush,
           fwd_a, fwd_b, max_start, max_err, stall_cnt, flush_cnt
  );

  modport slave (
    input  ifid_op, ifid_rs, ifid_rt, idex_op, idex_rs, idex_rt, idex_rd,
           idex_regwrt, idex_memread, exmem_rd, exmem_regwrt, memwb_rd,
           memwb_regwrt, ex_redirect, mem_redirect, max_done,
    output pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush,
           fwd_a, fwd_b, max_start, max_err, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard, forwarding and MAX-sequencing controller for the IF/ID/EX/MEM/WB
// pipeline; also keeps saturating stall and redirect statistics.
module pipe_hazard_ctrl #(
  parameter int RAW         = 6,
  parameter int MAX_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  pipe_hazard_if.slave hz
);

  localparam int         TW     = $clog2(MAX_TIMEOUT + 1);
  localparam logic [3:0] OP_MAX = 4'b0001;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LDSTALL = 2'd1,
    MAXWAIT = 2'd2
  } state_t;

  // {uses_rt, uses_rs} for the instruction sitting in IF/ID
  function automatic logic [1:0] src_use(input logic [3:0] op);
    case (op)
      4'b0101, 4'b0110, 4'b1001, 4'b1011, 4'b1010, 4'b1110: src_use = 2'b01;
      4'b0100, 4'b0111, 4'b0011, 4'b0001:                   src_use = 2'b11;
      default:                                               src_use = 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] fwd_sel(input logic [RAW-1:0] src,
                                         input logic [RAW-1:0] ex_rd,
                                         input logic           ex_wr,
                                         input logic [RAW-1:0] wb_rd,
                                         input logic           wb_wr);
    if (ex_wr && (src == ex_rd)) begin
      fwd_sel = 2'b10;
    end else if (wb_wr && (src == wb_rd)) begin
      fwd_sel = 2'b01;
    end else begin
      fwd_sel = 2'b00;
    end
  endfunction

  state_t           state_r, state_nxt_s;
  logic [TW-1:0]    tmo_r;
  logic             max_start_r, max_err_r;
  logic [CNT_W-1:0] stall_cnt_r, flush_cnt_r;

  logic       pc_write_s, ifid_write_s, ifid_flush_s, idex_flush_s, exmem_flush_s;
  logic       flush_inc_s, start_nxt_s, err_set_s, max_exit_s;
  logic [1:0] uses_s;
  logic       load_use_s, tmo_hit_s;

  assign uses_s     = src_use(hz.ifid_op);
  assign load_use_s = hz.idex_memread & hz.idex_regwrt &
                      ((uses_s[0] & (hz.idex_rd == hz.ifid_rs)) |
                       (uses_s[1] & (hz.idex_rd == hz.ifid_rt)));
  assign tmo_hit_s  = (tmo_r == TW'(MAX_TIMEOUT - 1));

  // Next-state and pipeline-control decode; everything held low during reset
  always_comb begin
    state_nxt_s   = state_r;
    pc_write_s    = 1'b0;
    ifid_write_s  = 1'b0;
    ifid_flush_s  = 1'b0;
    idex_flush_s  = 1'b0;
    exmem_flush_s = 1'b0;
    flush_inc_s   = 1'b0;
    start_nxt_s   = 1'b0;
    err_set_s     = 1'b0;
    max_exit_s    = 1'b0;
    if (!rst_n) begin
      state_nxt_s = RUN;
    end else begin
      case (state_r)
        RUN: begin
          pc_write_s   = 1'b1;
          ifid_write_s = 1'b1;
          if (hz.mem_redirect) begin
            ifid_flush_s  = 1'b1;
            idex_flush_s  = 1'b1;
            exmem_flush_s = 1'b1;
            flush_inc_s   = 1'b1;
          end else if (hz.ex_redirect) begin
            ifid_flush_s = 1'b1;
            idex_flush_s = 1'b1;
            flush_inc_s  = 1'b1;
          end else if (load_use_s) begin
            pc_write_s   = 1'b0;
            ifid_write_s = 1'b0;
            idex_flush_s = 1'b1;
            state_nxt_s  = LDSTALL;
          end else if (hz.idex_op == OP_MAX) begin
            pc_write_s   = 1'b0;
            ifid_write_s = 1'b0;
            start_nxt_s  = 1'b1;
            state_nxt_s  = MAXWAIT;
          end else begin
            state_nxt_s = RUN;
          end
        end
        LDSTALL: begin
          pc_write_s   = 1'b1;
          ifid_write_s = 1'b1;
          state_nxt_s  = RUN;
        end
        MAXWAIT: begin
          // MAX stays parked in ID/EX; the exit cycle bubbles it out
          if (hz.max_done) begin
            max_exit_s   = 1'b1;
            idex_flush_s = 1'b1;
            state_nxt_s  = RUN;
          end else if (tmo_hit_s) begin
            max_exit_s   = 1'b1;
            err_set_s    = 1'b1;
            idex_flush_s = 1'b1;
            state_nxt_s  = RUN;
          end else begin
            state_nxt_s = MAXWAIT;
          end
        end
        default: begin
          state_nxt_s = RUN;
        end
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= RUN;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // MAX timeout counter, start pulse and sticky error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_r       <= {TW{1'b0}};
      max_start_r <= 1'b0;
      max_err_r   <= 1'b0;
    end else begin
      if ((state_r == MAXWAIT) && !max_exit_s) begin
        tmo_r <= tmo_r + TW'(1);
      end else begin
        tmo_r <= {TW{1'b0}};
      end
      max_start_r <= start_nxt_s;
      max_err_r   <= max_err_r | err_set_s;
    end
  end

  // Saturating stall and redirect statistics
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (!pc_write_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
        stall_cnt_r <= stall_cnt_r + CNT_W'(1);
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (flush_inc_s && (flush_cnt_r != {CNT_W{1'b1}})) begin
        flush_cnt_r <= flush_cnt_r + CNT_W'(1);
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
    end
  end

  assign hz.pc_write    = pc_write_s;
  assign hz.ifid_write  = ifid_write_s;
  assign hz.ifid_flush  = ifid_flush_s;
  assign hz.idex_flush  = idex_flush_s;
  assign hz.exmem_flush = exmem_flush_s;
  assign hz.fwd_a       = rst_n ? fwd_sel(hz.idex_rs, hz.exmem_rd, hz.exmem_regwrt,
                                          hz.memwb_rd, hz.memwb_regwrt) : 2'b00;
  assign hz.fwd_b       = rst_n ? fwd_sel(hz.idex_rt, hz.exmem_rd, hz.exmem_regwrt,
                                          hz.memwb_rd, hz.memwb_regwrt) : 2'b00;
  assign hz.max_start   = max_start_r;
  assign hz.max_err     = max_err_r;
  assign hz.stall_cnt   = stall_cnt_r;
  assign hz.flush_cnt   = flush_cnt_r;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed-vector bench for pipe_hazard_ctrl (MAX_TIMEOUT=8, 4-bit counters so
// saturation is reachable quickly).
module tb_pipe_hazard_ctrl;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  pipe_hazard_if #(.RAW(6), .CNT_W(4)) hz ();

  pipe_hazard_ctrl #(.RAW(6), .MAX_TIMEOUT(8), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle();
    hz.ifid_op = 4'd0; hz.ifid_rs = 6'd0; hz.ifid_rt = 6'd0;
    hz.idex_op = 4'd0; hz.idex_rs = 6'd0; hz.idex_rt = 6'd0; hz.idex_rd = 6'd0;
    hz.idex_regwrt = 1'b0; hz.idex_memread = 1'b0;
    hz.exmem_rd = 6'd0; hz.exmem_regwrt = 1'b0;
    hz.memwb_rd = 6'd0; hz.memwb_regwrt = 1'b0;
    hz.ex_redirect = 1'b0; hz.mem_redirect = 1'b0; hz.max_done = 1'b0;
  endtask

  // advance one clock; inputs are then driven at posedge+1
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic set_load_use(input logic [5:0] rs, input logic [5:0] rt);
    hz.idex_op = 4'b1110; hz.idex_rd = 6'd3; hz.idex_memread = 1'b1; hz.idex_regwrt = 1'b1;
    hz.ifid_op = 4'b0100; hz.ifid_rs = rs; hz.ifid_rt = rt;
  endtask

  task automatic test_reset();
    idle();
    hz.exmem_rd = 6'd5; hz.exmem_regwrt = 1'b1; hz.idex_rs = 6'd5;
    rst_n = 1'b0;
    #1;
    checks++; if (hz.pc_write !== 1'b0) begin errors++; $display("FAIL rst_pc_write: got %b expected 0", hz.pc_write); end
    checks++; if (hz.ifid_write !== 1'b0) begin errors++; $display("FAIL rst_ifid_write: got %b expected 0", hz.ifid_write); end
    checks++; if (hz.fwd_a !== 2'b00) begin errors++; $display("FAIL rst_fwd_a: got %b expected 00", hz.fwd_a); end
    cyc();
    checks++; if (hz.max_start !== 1'b0 || hz.max_err !== 1'b0) begin errors++; $display("FAIL rst_max: got start=%b err=%b expected 0 0", hz.max_start, hz.max_err); end
    checks++; if (hz.stall_cnt !== 4'd0 || hz.flush_cnt !== 4'd0) begin errors++; $display("FAIL rst_cnt: got stall=%0d flush=%0d expected 0 0", hz.stall_cnt, hz.flush_cnt); end
    rst_n = 1'b1;
    #1;
    checks++; if (hz.pc_write !== 1'b1 || hz.ifid_write !== 1'b1) begin errors++; $display("FAIL rst_release_run: got pc=%b ifid=%b expected 1 1", hz.pc_write, hz.ifid_write); end
    checks++; if (hz.fwd_a !== 2'b10) begin errors++; $display("FAIL rst_release_fwd: got %b expected 10", hz.fwd_a); end
  endtask

  task automatic test_forward();
    do_reset();
    hz.exmem_rd = 6'd5; hz.exmem_regwrt = 1'b1; hz.memwb_rd = 6'd5; hz.memwb_regwrt = 1'b1;
    hz.idex_rs = 6'd5; hz.idex_rt = 6'd5;
    #1;
    checks++; if (hz.fwd_a !== 2'b10 || hz.fwd_b !== 2'b10) begin errors++; $display("FAIL fwd_both: got a=%b b=%b expected 10 10", hz.fwd_a, hz.fwd_b); end
    hz.exmem_regwrt = 1'b0;
    #1;
    checks++; if (hz.fwd_a !== 2'b01 || hz.fwd_b !== 2'b01) begin errors++; $display("FAIL fwd_memwb: got a=%b b=%b expected 01 01", hz.fwd_a, hz.fwd_b); end
    hz.exmem_rd = 6'd2; hz.exmem_regwrt = 1'b1; hz.memwb_rd = 6'd3;
    hz.idex_rs = 6'd2; hz.idex_rt = 6'd3;
    #1;
    checks++; if (hz.fwd_a !== 2'b10 || hz.fwd_b !== 2'b01) begin errors++; $display("FAIL fwd_split: got a=%b b=%b expected 10 01", hz.fwd_a, hz.fwd_b); end
    hz.memwb_rd = 6'd0; hz.idex_rs = 6'd0; hz.idex_rt = 6'd7;
    #1;
    checks++; if (hz.fwd_a !== 2'b01 || hz.fwd_b !== 2'b00) begin errors++; $display("FAIL fwd_r0: got a=%b b=%b expected 01 00", hz.fwd_a, hz.fwd_b); end
    hz.memwb_regwrt = 1'b0;
    #1;
    checks++; if (hz.fwd_a !== 2'b00) begin errors++; $display("FAIL fwd_none: got a=%b expected 00", hz.fwd_a); end
  endtask

  task automatic test_load_use();
    do_reset();
    set_load_use(6'd3, 6'd9);
    #1;
    checks++; if (hz.pc_write !== 1'b0 || hz.ifid_write !== 1'b0) begin errors++; $display("FAIL lu_stall: got pc=%b ifid=%b expected 0 0", hz.pc_write, hz.ifid_write); end
    checks++; if (hz.idex_flush !== 1'b1 || hz.ifid_flush !== 1'b0) begin errors++; $display("FAIL lu_flush: got idex=%b ifid=%b expected 1 0", hz.idex_flush, hz.ifid_flush); end
    cyc();
    idle();
    #1;
    checks++; if (hz.pc_write !== 1'b1 || hz.ifid_write !== 1'b1) begin errors++; $display("FAIL lu_resume: got pc=%b ifid=%b expected 1 1", hz.pc_write, hz.ifid_write); end
    checks++; if (hz.stall_cnt !== 4'd1) begin errors++; $display("FAIL lu_stall_cnt: got %0d expected 1", hz.stall_cnt); end
    cyc();
    // rt match for a two-source op also stalls
    set_load_use(6'd9, 6'd3);
    #1;
    checks++; if (hz.pc_write !== 1'b0) begin errors++; $display("FAIL lu_rt: got pc=%b expected 0", hz.pc_write); end
    cyc();
    idle();
    cyc();
    // INC only reads rs, J reads nothing, non-load does not stall
    set_load_use(6'd9, 6'd3); hz.ifid_op = 4'b0101;
    #1;
    checks++; if (hz.pc_write !== 1'b1) begin errors++; $display("FAIL lu_inc_rt: got pc=%b expected 1", hz.pc_write); end
    hz.ifid_op = 4'b1000; hz.ifid_rs = 6'd3;
    #1;
    checks++; if (hz.pc_write !== 1'b1) begin errors++; $display("FAIL lu_jump: got pc=%b expected 1", hz.pc_write); end
    hz.ifid_op = 4'b0100; hz.idex_memread = 1'b0;
    #1;
    checks++; if (hz.pc_write !== 1'b1) begin errors++; $display("FAIL lu_noload: got pc=%b expected 1", hz.pc_write); end
    idle();
    cyc();
    checks++; if (hz.stall_cnt !== 4'd2) begin errors++; $display("FAIL lu_stall_cnt2: got %0d expected 2", hz.stall_cnt); end
  endtask

  task automatic test_redirect_priority();
    do_reset();
    set_load_use(6'd3, 6'd0);
    hz.ex_redirect = 1'b1;
    #1;
    checks++; if ({hz.ifid_flush, hz.idex_flush, hz.exmem_flush} !== 3'b110) begin errors++; $display("FAIL rd_ex_flush: got %b expected 110", {hz.ifid_flush, hz.idex_flush, hz.exmem_flush}); end
    checks++; if (hz.pc_write !== 1'b1) begin errors++; $display("FAIL rd_ex_pc: got %b expected 1", hz.pc_write); end
    cyc();
    hz.ex_redirect = 1'b0;
    #1;
    // a fresh load-use stalls only if the FSM stayed in RUN
    checks++; if (hz.pc_write !== 1'b0) begin errors++; $display("FAIL rd_stay_run: got pc=%b expected 0", hz.pc_write); end
    checks++; if (hz.flush_cnt !== 4'd1) begin errors++; $display("FAIL rd_flush_cnt1: got %0d expected 1", hz.flush_cnt); end
    cyc();
    idle();
    cyc();
    hz.mem_redirect = 1'b1; hz.ex_redirect = 1'b1; hz.idex_op = 4'b0001;
    #1;
    checks++; if ({hz.ifid_flush, hz.idex_flush, hz.exmem_flush} !== 3'b111) begin errors++; $display("FAIL rd_mem_flush: got %b expected 111", {hz.ifid_flush, hz.idex_flush, hz.exmem_flush}); end
    checks++; if (hz.pc_write !== 1'b1) begin errors++; $display("FAIL rd_mem_pc: got %b expected 1", hz.pc_write); end
    cyc();
    idle();
    #1;
    checks++; if (hz.max_start !== 1'b0 || hz.pc_write !== 1'b1) begin errors++; $display("FAIL rd_max_ignored: got start=%b pc=%b expected 0 1", hz.max_start, hz.pc_write); end
    checks++; if (hz.flush_cnt !== 4'd2) begin errors++; $display("FAIL rd_flush_cnt2: got %0d expected 2", hz.flush_cnt); end
  endtask

  task automatic test_max_done();
    do_reset();
    hz.idex_op = 4'b0001;
    hz.idex_rs = 6'd5; hz.exmem_rd = 6'd5; hz.exmem_regwrt = 1'b1;
    #1;
    checks++; if (hz.pc_write !== 1'b0 || hz.idex_flush !== 1'b0 || hz.max_start !== 1'b0) begin errors++; $display("FAIL max_detect: got pc=%b idex_flush=%b start=%b expected 0 0 0", hz.pc_write, hz.idex_flush, hz.max_start); end
    cyc();
    for (int k = 1; k <= 8; k++) begin
      hz.max_done    = (k == 8);
      hz.ex_redirect = (k == 4);
      #1;
      checks++; if (hz.max_start !== (k == 1)) begin errors++; $display("FAIL max_start_k%0d: got %b expected %b", k, hz.max_start, (k == 1)); end
      checks++; if (hz.pc_write !== 1'b0 || hz.ifid_write !== 1'b0 || hz.ifid_flush !== 1'b0) begin errors++; $display("FAIL max_hold_k%0d: got pc=%b ifid_w=%b ifid_f=%b expected 0 0 0", k, hz.pc_write, hz.ifid_write, hz.ifid_flush); end
      checks++; if (hz.idex_flush !== (k == 8)) begin errors++; $display("FAIL max_idex_flush_k%0d: got %b expected %b", k, hz.idex_flush, (k == 8)); end
      if (k == 3) begin
        checks++; if (hz.fwd_a !== 2'b10) begin errors++; $display("FAIL max_fwd: got %b expected 10", hz.fwd_a); end
      end
      cyc();
    end
    idle();
    #1;
    checks++; if (hz.pc_write !== 1'b1 || hz.max_err !== 1'b0 || hz.max_start !== 1'b0) begin errors++; $display("FAIL max_exit: got pc=%b err=%b start=%b expected 1 0 0", hz.pc_write, hz.max_err, hz.max_start); end
    checks++; if (hz.stall_cnt !== 4'd9 || hz.flush_cnt !== 4'd0) begin errors++; $display("FAIL max_counts: got stall=%0d flush=%0d expected 9 0", hz.stall_cnt, hz.flush_cnt); end
  endtask

  task automatic test_max_timeout();
    do_reset();
    hz.idex_op = 4'b0001;
    cyc();
    for (int k = 1; k <= 8; k++) begin
      #1;
      checks++; if (hz.idex_flush !== (k == 8)) begin errors++; $display("FAIL tmo_exit_k%0d: got %b expected %b", k, hz.idex_flush, (k == 8)); end
      checks++; if (hz.max_err !== 1'b0) begin errors++; $display("FAIL tmo_early_err_k%0d: got %b expected 0", k, hz.max_err); end
      cyc();
    end
    idle();
    #1;
    checks++; if (hz.max_err !== 1'b1 || hz.pc_write !== 1'b1) begin errors++; $display("FAIL tmo_err: got err=%b pc=%b expected 1 1", hz.max_err, hz.pc_write); end
    cyc();
    hz.idex_op = 4'b0001;
    cyc();
    for (int k = 1; k <= 3; k++) begin
      hz.max_done = (k == 3);
      #1;
      checks++; if (hz.idex_flush !== (k == 3)) begin errors++; $display("FAIL tmo_next_k%0d: got %b expected %b", k, hz.idex_flush, (k == 3)); end
      cyc();
    end
    idle();
    #1;
    checks++; if (hz.max_err !== 1'b1 || hz.pc_write !== 1'b1) begin errors++; $display("FAIL tmo_sticky: got err=%b pc=%b expected 1 1", hz.max_err, hz.pc_write); end
  endtask

  task automatic test_reset_mid_max();
    do_reset();
    hz.idex_op = 4'b0001;
    cyc();
    hz.exmem_rd = 6'd5; hz.exmem_regwrt = 1'b1; hz.idex_rs = 6'd5; hz.max_done = 1'b1;
    #1;
    checks++; if (hz.max_start !== 1'b1 || hz.idex_flush !== 1'b1 || hz.fwd_a !== 2'b10) begin errors++; $display("FAIL mid_pre: got start=%b idex_flush=%b fwd_a=%b expected 1 1 10", hz.max_start, hz.idex_flush, hz.fwd_a); end
    rst_n = 1'b0;
    #1;
    checks++; if (hz.max_start !== 1'b0 || hz.idex_flush !== 1'b0 || hz.fwd_a !== 2'b00 || hz.pc_write !== 1'b0) begin errors++; $display("FAIL mid_async: got start=%b idex_flush=%b fwd_a=%b pc=%b expected 0 0 00 0", hz.max_start, hz.idex_flush, hz.fwd_a, hz.pc_write); end
    cyc();
    rst_n = 1'b1;
    idle();
    #1;
    checks++; if (hz.pc_write !== 1'b1 || hz.max_start !== 1'b0 || hz.max_err !== 1'b0) begin errors++; $display("FAIL mid_release: got pc=%b start=%b err=%b expected 1 0 0", hz.pc_write, hz.max_start, hz.max_err); end
    checks++; if (hz.stall_cnt !== 4'd0 || hz.flush_cnt !== 4'd0) begin errors++; $display("FAIL mid_cnt: got stall=%0d flush=%0d expected 0 0", hz.stall_cnt, hz.flush_cnt); end
    cyc();
    checks++; if (hz.max_start !== 1'b0) begin errors++; $display("FAIL mid_no_start: got %b expected 0", hz.max_start); end
  endtask

  task automatic run_max_timeout();
    hz.idex_op = 4'b0001;
    cyc();
    repeat (7) cyc();
    hz.idex_op = 4'd0;
    cyc();
  endtask

  task automatic test_saturation();
    do_reset();
    run_max_timeout();
    #1;
    checks++; if (hz.stall_cnt !== 4'd9) begin errors++; $display("FAIL sat_stall9: got %0d expected 9", hz.stall_cnt); end
    run_max_timeout();
    #1;
    checks++; if (hz.stall_cnt !== 4'd15) begin errors++; $display("FAIL sat_stall: got %0d expected 15", hz.stall_cnt); end
    set_load_use(6'd3, 6'd0);
    cyc();
    idle();
    cyc();
    checks++; if (hz.stall_cnt !== 4'd15) begin errors++; $display("FAIL sat_stall_hold: got %0d expected 15", hz.stall_cnt); end
    repeat (14) begin
      hz.ex_redirect = 1'b1;
      cyc();
    end
    checks++; if (hz.flush_cnt !== 4'd14) begin errors++; $display("FAIL sat_flush14: got %0d expected 14", hz.flush_cnt); end
    repeat (2) cyc();
    hz.ex_redirect = 1'b0; hz.mem_redirect = 1'b1;
    cyc();
    hz.mem_redirect = 1'b0;
    checks++; if (hz.flush_cnt !== 4'd15) begin errors++; $display("FAIL sat_flush: got %0d expected 15", hz.flush_cnt); end
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    test_reset();
    test_forward();
    test_load_use();
    test_redirect_priority();
    test_max_done();
    test_max_timeout();
    test_reset_mid_max();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
